// File: rtl/term_screen.sv
// Character-cell screen buffer rendered to a byte-wide UART TX, with vi-style cursor/insert
// handling, full-screen refresh framing and on-demand hex display fields.
module term_screen #(
  parameter int COLS         = 40,
  parameter int ROWS         = 24,
  parameter int NFIELDS      = 2,
  parameter int DIGITS       = 8,
  parameter int FIELD_BASE   = 155,
  parameter int FIELD_STRIDE = 40,
  localparam int N  = COLS * ROWS,
  localparam int AW = $clog2(N)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  i_byte,
  input  logic                        i_byte_v,
  output logic [7:0]                  o_byte,
  output logic                        o_byte_v,
  input  logic                        i_tx_active,
  input  logic                        i_tx_done,
  input  logic [NFIELDS*DIGITS*4-1:0] i_field_data,
  input  logic                        i_field_upd,
  output logic                        o_busy,
  output logic [AW-1:0]               o_cursor,
  output logic                        o_mode
);

  localparam int FW = NFIELDS * DIGITS * 4;
  localparam logic [AW-1:0] LAST   = AW'(N - 1);
  localparam logic [AW-1:0] CMAX   = AW'(COLS - 1);
  localparam logic [AW-1:0] RMAX   = AW'(ROWS - 1);
  localparam logic [AW-1:0] COLS_A = AW'(COLS);

  typedef enum logic [2:0] {S_CLEAR, S_REFRESH, S_IDLE, S_SEND, S_FIELD} state_t;

  state_t          r_state;
  logic            r_wait;
  logic [AW-1:0]   r_clr, r_ref_addr, r_ref_col, r_col, r_row;
  logic [2:0]      r_ph;
  logic            r_last;
  logic [3:0][7:0] r_seq;
  logic [2:0]      r_idx, r_len;
  logic            r_fpend;
  logic [FW-1:0]   r_fdata, r_fwork;
  logic [7:0]      r_fk, r_fd;
  logic [7:0]      r_mem [N];
  logic [7:0]      r_rdata;

  logic            w_tx_free, w_printable, w_we;
  logic [31:0]     w_faddr, w_noff;
  logic [3:0]      w_nib;
  logic [7:0]      w_fchar, w_wdata, w_ref_byte;
  logic [AW-1:0]   w_waddr;
  logic            w_unused;

  assign w_unused    = i_tx_active;
  assign o_busy      = (r_state != S_IDLE);
  // A done pulse coinciding with our own strobe belongs to the previous byte.
  assign w_tx_free   = !r_wait || (i_tx_done && !o_byte_v);
  assign w_printable = (i_byte >= 8'h20) && (i_byte <= 8'h7e);
  assign w_faddr     = 32'(FIELD_BASE) + 32'(r_fk) * 32'(FIELD_STRIDE) + 32'(r_fd);
  assign w_noff      = (32'(r_fk) * 32'(DIGITS) + 32'(DIGITS - 1) - 32'(r_fd)) << 2;
  assign w_nib       = 4'(r_fwork >> w_noff);
  assign w_fchar     = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib}) : (8'h57 + {4'h0, w_nib});

  always_comb begin
    w_we    = 1'b0;
    w_waddr = o_cursor;
    w_wdata = i_byte;
    case (r_state)
      S_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_clr;
        w_wdata = 8'h20;
      end
      S_FIELD: begin
        w_we    = (w_faddr < 32'(N));
        w_waddr = w_faddr[AW-1:0];
        w_wdata = w_fchar;
      end
      S_IDLE:  w_we = i_byte_v && o_mode && w_printable;
      default: ;
    endcase
  end

  always_comb begin
    case (r_ph)
      3'd0:    w_ref_byte = 8'h1b;
      3'd1:    w_ref_byte = 8'h5b;
      3'd2:    w_ref_byte = 8'h48;
      3'd3:    w_ref_byte = r_rdata;
      3'd4:    w_ref_byte = 8'h0d;
      default: w_ref_byte = 8'h0a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
    r_rdata <= r_mem[r_ref_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_CLEAR;
      r_wait     <= 1'b0;
      r_clr      <= '0;
      r_ref_addr <= '0;
      r_ref_col  <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_ph       <= 3'd0;
      r_last     <= 1'b0;
      r_seq      <= '0;
      r_idx      <= 3'd0;
      r_len      <= 3'd0;
      r_fpend    <= 1'b0;
      r_fdata    <= '0;
      r_fwork    <= '0;
      r_fk       <= 8'd0;
      r_fd       <= 8'd0;
      o_byte     <= 8'h00;
      o_byte_v   <= 1'b0;
      o_cursor   <= '0;
      o_mode     <= 1'b0;
    end else begin
      o_byte_v <= 1'b0;
      if (r_wait && i_tx_done && !o_byte_v) r_wait <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          if (r_clr == LAST) begin
            r_state    <= S_REFRESH;
            r_ph       <= 3'd0;
            r_ref_addr <= '0;
            r_ref_col  <= '0;
            r_last     <= 1'b0;
          end else begin
            r_clr <= r_clr + 1'b1;
          end
        end
        S_REFRESH: if (w_tx_free) begin
          if (r_ph == 3'd6) begin
            r_state <= S_IDLE;
          end else begin
            o_byte   <= w_ref_byte;
            o_byte_v <= 1'b1;
            r_wait   <= 1'b1;
            case (r_ph)
              3'd3: begin
                // The read address advances here, leaving a full cycle for the RAM before the next cell.
                if (r_ref_col == CMAX) begin
                  r_ref_col <= '0;
                  r_ph      <= 3'd4;
                end else begin
                  r_ref_col <= r_ref_col + 1'b1;
                end
                if (r_ref_addr == LAST) r_last <= 1'b1;
                else                    r_ref_addr <= r_ref_addr + 1'b1;
              end
              3'd5:    r_ph <= r_last ? 3'd6 : 3'd3;
              default: r_ph <= r_ph + 3'd1;
            endcase
          end
        end
        S_SEND: if (w_tx_free) begin
          if (r_idx == r_len) begin
            r_state <= S_IDLE;
          end else begin
            o_byte   <= r_seq[r_idx[1:0]];
            o_byte_v <= 1'b1;
            r_wait   <= 1'b1;
            r_idx    <= r_idx + 3'd1;
          end
        end
        S_FIELD: begin
          if (r_fd == 8'(DIGITS - 1)) begin
            r_fd <= 8'd0;
            if (r_fk == 8'(NFIELDS - 1)) r_state <= S_IDLE;
            else                         r_fk <= r_fk + 8'd1;
          end else begin
            r_fd <= r_fd + 8'd1;
          end
        end
        S_IDLE: begin
          if (i_byte_v) begin
            r_idx <= 3'd0;
            if (!o_mode) begin
              case (i_byte)
                "h": if (r_col != '0) begin
                  o_cursor <= o_cursor - 1'b1;
                  r_col    <= r_col - 1'b1;
                  r_seq    <= {8'h00, 8'h44, 8'h5b, 8'h1b};
                  r_len    <= 3'd3;
                  r_state  <= S_SEND;
                end
                "l": if (r_col != CMAX) begin
                  o_cursor <= o_cursor + 1'b1;
                  r_col    <= r_col + 1'b1;
                  r_seq    <= {8'h00, 8'h43, 8'h5b, 8'h1b};
                  r_len    <= 3'd3;
                  r_state  <= S_SEND;
                end
                "k": if (r_row != '0) begin
                  o_cursor <= o_cursor - COLS_A;
                  r_row    <= r_row - 1'b1;
                  r_seq    <= {8'h00, 8'h41, 8'h5b, 8'h1b};
                  r_len    <= 3'd3;
                  r_state  <= S_SEND;
                end
                "j": if (r_row != RMAX) begin
                  o_cursor <= o_cursor + COLS_A;
                  r_row    <= r_row + 1'b1;
                  r_seq    <= {8'h00, 8'h42, 8'h5b, 8'h1b};
                  r_len    <= 3'd3;
                  r_state  <= S_SEND;
                end
                " ": begin
                  r_state    <= S_REFRESH;
                  r_ph       <= 3'd0;
                  r_ref_addr <= '0;
                  r_ref_col  <= '0;
                  r_last     <= 1'b0;
                end
                "i":     o_mode <= 1'b1;
                default: ;
              endcase
            end else if (i_byte == 8'h1b) begin
              o_mode <= 1'b0;
            end else if (w_printable) begin
              r_state <= S_SEND;
              if (o_cursor == LAST) begin
                o_cursor <= '0;
                r_col    <= '0;
                r_row    <= '0;
                r_seq    <= {8'h48, 8'h5b, 8'h1b, i_byte};
                r_len    <= 3'd4;
              end else if (r_col == CMAX) begin
                o_cursor <= o_cursor + 1'b1;
                r_col    <= '0;
                r_row    <= r_row + 1'b1;
                r_seq    <= {8'h00, 8'h0a, 8'h0d, i_byte};
                r_len    <= 3'd3;
              end else begin
                o_cursor <= o_cursor + 1'b1;
                r_col    <= r_col + 1'b1;
                r_seq    <= {24'h000000, i_byte};
                r_len    <= 3'd1;
              end
            end
          end else if (r_fpend) begin
            r_state <= S_FIELD;
            r_fpend <= 1'b0;
            r_fwork <= r_fdata;
            r_fk    <= 8'd0;
            r_fd    <= 8'd0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // A strobe in the same cycle as the field-write start re-arms pending with the newer data.
      if (i_field_upd) begin
        r_fdata <= i_field_data;
        r_fpend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_term_screen.sv
// Scoreboard bench for term_screen on a 4x2 screen with two 3-digit fields (one digit falls off-screen).
module tb_term_screen;

  localparam int COLS = 4;
  localparam int ROWS = 2;
  localparam int NF   = 2;
  localparam int DG   = 3;
  localparam int FB   = 1;
  localparam int FS   = 5;
  localparam int N    = COLS * ROWS;
  localparam int AW   = $clog2(N);

  logic              clk;
  logic              rst;
  logic [7:0]        i_byte;
  logic              i_byte_v;
  logic [7:0]        o_byte;
  logic              o_byte_v;
  logic              i_tx_active;
  logic              i_tx_done;
  logic [NF*DG*4-1:0] i_field_data;
  logic              i_field_upd;
  logic              o_busy;
  logic [AW-1:0]     o_cursor;
  logic              o_mode;

  logic [7:0] exp_q [$];
  logic [7:0] shadow [N];
  int n_cmp    = 0;
  int n_bad    = 0;
  int n_strobe = 0;
  bit outst    = 1'b0;
  int tx_mode  = 0;
  int tx_dly   = 1;

  term_screen #(
    .COLS(COLS), .ROWS(ROWS), .NFIELDS(NF), .DIGITS(DG),
    .FIELD_BASE(FB), .FIELD_STRIDE(FS)
  ) dut (
    .clk(clk), .rst(rst),
    .i_byte(i_byte), .i_byte_v(i_byte_v),
    .o_byte(o_byte), .o_byte_v(o_byte_v),
    .i_tx_active(i_tx_active), .i_tx_done(i_tx_done),
    .i_field_data(i_field_data), .i_field_upd(i_field_upd),
    .o_busy(o_busy), .o_cursor(o_cursor), .o_mode(o_mode)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // UART model: done pulse tx_dly cycles after each strobe, or done held high in mode 1.
  initial begin
    int dcnt;
    dcnt = 0;
    i_tx_done = 1'b0;
    i_tx_active = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_mode == 1) begin
        i_tx_done = 1'b1;
      end else begin
        i_tx_done = 1'b0;
        if (o_byte_v) dcnt = tx_dly;
        else if (dcnt > 0) begin
          dcnt--;
          if (dcnt == 0) i_tx_done = 1'b1;
        end
      end
      i_tx_active = (dcnt > 0);
    end
  end

  // Monitor: every transmit strobe pops one expected byte.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (o_byte_v) begin
        n_strobe++;
        n_cmp++;
        if (outst) begin
          n_bad++;
          $display("FAIL tx_handshake: strobe before previous byte acknowledged, outstanding=%0d required 0", outst);
        end
        outst = 1'b1;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL tx_unexpected: got byte %02h, required no byte", o_byte);
        end else begin
          e = exp_q.pop_front();
          if (o_byte !== e) begin
            n_bad++;
            $display("FAIL tx_byte #%0d: got %02h, required %02h", n_strobe, o_byte, e);
          end
        end
      end else if (i_tx_done) begin
        outst = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    n_bad++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    i_byte   = b;
    i_byte_v = 1'b1;
    @(negedge clk);
    i_byte_v = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (o_busy && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (o_busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: o_busy still 1 after %0d cycles, required 0", name, t);
    end
  endtask

  task automatic push_esc(input logic [7:0] c);
    exp_q.push_back(8'h1b);
    exp_q.push_back(8'h5b);
    exp_q.push_back(c);
  endtask

  task automatic push_refresh();
    push_esc(8'h48);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) exp_q.push_back(shadow[r*COLS + c]);
      exp_q.push_back(8'h0d);
      exp_q.push_back(8'h0a);
    end
  endtask

  // Cycles from reset release to the first strobe: N clear cycles plus one.
  task automatic measure_clr();
    int t;
    t = 0;
    while (!o_byte_v && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("clr_latency", t, N + 1);
  endtask

  logic [7:0] cmd_b   [12] = '{"h", "k", "l", "j", "j", "l", "l", "l", "k", "h", "l", "q"};
  int         cmd_cur [12] = '{0, 0, 1, 5, 5, 6, 7, 7, 3, 2, 3, 3};
  logic [7:0] cmd_dir [12] = '{8'h00, 8'h00, "C", "B", 8'h00, "C", "C", 8'h00, "A", "D", "C", 8'h00};

  logic [7:0] ins_b    [6] = '{"A", "B", 8'h07, "h", "j", "l"};
  int         ins_cur  [6] = '{4, 5, 5, 6, 7, 0};
  int         ins_echo [6] = '{1, 1, 0, 1, 1, 1};
  int         ins_tail [6] = '{1, 0, 0, 0, 0, 2};

  initial begin
    int k, t, busy_n;
    rst          = 1'b0;
    i_byte       = 8'h00;
    i_byte_v     = 1'b0;
    i_field_data = '0;
    i_field_upd  = 1'b0;
    #2 rst = 1'b1;
    for (int i = 0; i < N; i++) shadow[i] = 8'h20;
    push_refresh();
    @(negedge clk);
    chk("rst_byte_v", o_byte_v, 0);
    chk("rst_cursor", int'(o_cursor), 0);
    chk("rst_mode", o_mode, 0);
    chk("rst_busy", o_busy, 1);
    @(negedge clk);
    rst = 1'b0;
    measure_clr();
    wait_idle("refresh0");
    chk("boot_queue_drained", exp_q.size(), 0);

    // Cursor moves, including clamps at every screen edge.
    for (int i = 0; i < 12; i++) begin
      if (cmd_dir[i] != 8'h00) push_esc(cmd_dir[i]);
      send_byte(cmd_b[i]);
      chk("cmd_cursor", int'(o_cursor), cmd_cur[i]);
      wait_idle("cmd");
    end

    // Insert mode from cursor 3: row wrap, ignored control byte, screen wrap.
    tx_dly = 3;
    send_byte("i");
    chk("mode_insert", o_mode, 1);
    for (int i = 0; i < 6; i++) begin
      if (ins_echo[i] == 1) exp_q.push_back(ins_b[i]);
      if (ins_tail[i] == 1) begin
        exp_q.push_back(8'h0d);
        exp_q.push_back(8'h0a);
      end else if (ins_tail[i] == 2) begin
        push_esc(8'h48);
      end
      send_byte(ins_b[i]);
      chk("ins_cursor", int'(o_cursor), ins_cur[i]);
      wait_idle("ins");
    end
    send_byte(8'h1b);
    chk("mode_command", o_mode, 0);
    shadow[3] = "A";
    shadow[4] = "B";
    shadow[5] = "h";
    shadow[6] = "j";
    shadow[7] = "l";

    // Byte and field strobe together: refresh shows the old screen, field write follows.
    push_refresh();
    @(negedge clk);
    i_byte       = " ";
    i_byte_v     = 1'b1;
    i_field_data = 24'h111111;
    i_field_upd  = 1'b1;
    @(negedge clk);
    i_byte_v    = 1'b0;
    i_field_upd = 1'b0;
    repeat (4) @(negedge clk);
    send_byte("i");
    @(negedge clk);
    i_field_data = 24'h9c0b5a;
    i_field_upd  = 1'b1;
    @(negedge clk);
    i_field_upd = 1'b0;
    wait_idle("refresh1");
    chk("drop_during_refresh_mode", o_mode, 0);
    @(negedge clk);
    busy_n = 0;
    t = 0;
    while (o_busy && t < 50) begin
      busy_n++;
      t++;
      @(negedge clk);
    end
    chk("field_wr_cycles", busy_n, NF * DG);
    shadow[1] = "b";
    shadow[2] = "5";
    shadow[3] = "a";
    shadow[6] = "9";
    shadow[7] = "c";
    push_refresh();
    send_byte(" ");
    wait_idle("refresh2");

    push_esc("C");
    send_byte("l");
    chk("cursor_before_rst", int'(o_cursor), 1);
    wait_idle("move");

    // Reset in the middle of a refresh, right on a strobe.
    tx_dly = 1;
    push_refresh();
    send_byte(" ");
    k = 0;
    t = 0;
    while (k < 6 && t < 500) begin
      @(negedge clk);
      t++;
      if (o_byte_v) k++;
    end
    chk("mid_refresh_strobes", k, 6);
    #2 rst = 1'b1;
    exp_q.delete();
    tx_mode = 1;
    #1;
    chk("arst_byte_v", o_byte_v, 0);
    chk("arst_cursor", int'(o_cursor), 0);
    chk("arst_busy", o_busy, 1);
    for (int i = 0; i < N; i++) shadow[i] = 8'h20;
    push_refresh();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    measure_clr();
    wait_idle("refresh3");
    repeat (3) @(negedge clk);
    chk("final_cursor", int'(o_cursor), 0);
    chk("final_mode", o_mode, 0);
    chk("final_queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
